// File: rtl/arith_pkg.sv
// Shared arithmetic-library types and elaboration helpers.
// Combinational only; no latency or flow control.
package arith_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} serial_sub_state_t;

  function automatic int ndig(input int width, input int digit);
    return (digit > 0) ? width / digit : 1;
  endfunction

  // Legal digit-serial geometry: at least 2 bits, digit size divides width.
  function automatic bit sub_geom_ok(input int width, input int digit);
    return (width >= 2) && (digit > 0) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// DIGIT-bit ripple of full-subtractor cells; purely combinational,
// zero latency, no flow control.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] c;

  assign c[0] = bi;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign d[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (~x[i] & y[i]) | (~x[i] & c[i]) | (y[i] & c[i]);
  end

  assign bo = c[DIGIT];

endmodule

// File: rtl/serial_sub.sv
// Digit-serial a - b - bin; result and done appear WIDTH/DIGIT edges after the accepting edge.
// start is only sampled while busy is low; requests during busy are dropped.
module serial_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = $clog2(NDIG + 1);

  if (!sub_geom_ok(WIDTH, DIGIT)) begin : g_bad_geom
    $fatal(1, "serial_sub: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  serial_sub_state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb, sd, sd_nxt;
  logic             brw, am, bm;
  logic [DIGIT-1:0] dig_d;
  logic             dig_bo;
  logic             last;

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (sa[DIGIT-1:0]),
    .y  (sb[DIGIT-1:0]),
    .bi (brw),
    .d  (dig_d),
    .bo (dig_bo)
  );

  assign last = (cnt == CW'(1));
  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // New digit enters at the top so the low digit ends up at bit 0 after NDIG shifts.
  always_comb begin
    sd_nxt = sd >> DIGIT;
    sd_nxt[WIDTH-1 -: DIGIT] = dig_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sa   <= '0;
      sb   <= '0;
      sd   <= '0;
      brw  <= 1'b0;
      am   <= 1'b0;
      bm   <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            sd  <= '0;
            brw <= bin;
            am  <= a[WIDTH-1];
            bm  <= b[WIDTH-1];
            cnt <= CW'(NDIG);
          end
        end
        RUN: begin
          sa  <= sa >> DIGIT;
          sb  <= sb >> DIGIT;
          sd  <= sd_nxt;
          brw <= dig_bo;
          cnt <= cnt - CW'(1);
          if (last) begin
            diff <= sd_nxt;
            bout <= dig_bo;
            ovf  <= (am ^ bm) & (sd_nxt[WIDTH-1] ^ am);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench: three serial_sub instances (DIGIT = 4, 1, 16) checked
// against an integer-arithmetic reference model.
module tb_serial_sub;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         start_v [3];
  logic         busy_v  [3];
  logic         done_v  [3];
  logic [W-1:0] diff_v  [3];
  logic         bout_v  [3];
  logic         ovf_v   [3];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q0[$], q1[$], q2[$];
  exp_t last_e [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    serial_sub #(.WIDTH(W), .DIGIT(DG)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_v[g]),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .diff  (diff_v[g]),
      .bout  (bout_v[g]),
      .ovf   (ovf_v[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 1;
  endfunction

  // Reference: plain integer subtraction, borrow from sign of the unsigned
  // result, overflow from the signed result leaving the 16-bit range.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xbi, input int due);
    exp_t e;
    int   ur, sr;
    ur    = int'(xa) - int'(xb) - int'(xbi);
    sr    = int'($signed(xa)) - int'($signed(xb)) - int'(xbi);
    e.d   = ur[W-1:0];
    e.bo  = (ur < 0);
    e.ov  = (sr > 32767) || (sr < -32768);
    e.due = due;
    return e;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic push(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int i, output exp_t e);
    case (i)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
  endfunction

  function automatic int qdue(input int i);
    return (i == 0) ? q0[0].due : (i == 1) ? q1[0].due : q2[0].due;
  endfunction

  // Monitor: pops on done, checks latency, result hold and reset values.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        chk("rst_busy", i, 32'(busy_v[i]), 32'd0);
        chk("rst_done", i, 32'(done_v[i]), 32'd0);
        chk("rst_diff", i, 32'(diff_v[i]), 32'd0);
        chk("rst_bout", i, 32'(bout_v[i]), 32'd0);
        chk("rst_ovf",  i, 32'(ovf_v[i]),  32'd0);
      end else if (done_v[i]) begin
        if (qsize(i) == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL spurious_done inst%0d cyc%0d: got done=1 expected no done", i, cyc);
        end else begin
          exp_t e;
          pop(i, e);
          chk("diff",    i, 32'(diff_v[i]), 32'(e.d));
          chk("bout",    i, 32'(bout_v[i]), 32'(e.bo));
          chk("ovf",     i, 32'(ovf_v[i]),  32'(e.ov));
          chk("latency", i, 32'(cyc),       32'(e.due));
          last_e[i] = e;
        end
      end else begin
        chk("hold_diff", i, 32'(diff_v[i]), 32'(last_e[i].d));
        chk("hold_bout", i, 32'(bout_v[i]), 32'(last_e[i].bo));
        chk("hold_ovf",  i, 32'(ovf_v[i]),  32'(last_e[i].ov));
        if (qsize(i) != 0 && cyc > qdue(i)) begin
          exp_t e;
          pop(i, e);
          n_chk++;
          n_err++;
          $display("FAIL timeout inst%0d cyc%0d: no done, expected by cyc %0d", i, cyc, e.due);
        end
      end
    end
  end

  task automatic issue(input int i, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbi);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_v[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    a   = xa;
    b   = xb;
    bin = xbi;
    start_v[i] = 1'b1;
    push(i, model(xa, xb, xbi, cyc + 1 + lat_of(i)));
    @(posedge clk);
    #1 start_v[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int i = 0; i < 3; i++) last_e[i] = '{d: '0, bo: 1'b0, ov: 1'b0, due: 0};
  endtask

  initial begin
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed arithmetic cases on every digit size.
    for (int i = 0; i < 3; i++) begin
      issue(i, 16'h1234, 16'h0234, 1'b0);
      issue(i, 16'h0000, 16'h0001, 1'b0);
      issue(i, 16'h0005, 16'h0005, 1'b1);
      issue(i, 16'h8000, 16'h0001, 1'b0);
      issue(i, 16'h7FFF, 16'hFFFF, 1'b0);
      issue(i, 16'h8000, 16'h0000, 1'b1);
    end
    drain();

    // start during busy is dropped; then a back-to-back request on the done cycle.
    issue(0, 16'hA5A5, 16'h1111, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("busy_at_poke", 0, 32'(busy_v[0]), 32'd1);
    a = 16'hFFFF;
    b = 16'h0F0F;
    bin = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    issue(0, 16'h0100, 16'h0200, 1'b0);
    drain();

    // Reset in the middle of an operation.
    issue(0, 16'h4321, 16'h1234, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    clear_model();
    #1;
    chk("midrst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("midrst_done", 0, 32'(done_v[0]), 32'd0);
    chk("midrst_diff", 0, 32'(diff_v[0]), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized operands, all three instances running concurrently.
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra, rb;
      logic         rbi;
      int           sel;
      sel = int'($urandom_range(0, 2));
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom);
      if (($urandom & 7) == 0) ra = {1'b1, {(W-1){1'b0}}};
      if (($urandom & 7) == 0) rb = {1'b0, {(W-1){1'b1}}};
      issue(sel, ra, rb, rbi);
    end
    drain();
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (qsize(i) != 0) begin
        n_err++;
        $display("FAIL leftover inst%0d: %0d results never arrived, expected 0", i, qsize(i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
